// File: rtl/mapper_pkg.sv
// Shared constants for the multi-mapper cartridge block.
package mapper_pkg;

    // iNES mapper numbers that get their own decode; everything else is NROM
    localparam logic [7:0] MAP_NROM  = 8'd0;
    localparam logic [7:0] MAP_MMC1  = 8'd1;
    localparam logic [7:0] MAP_UXROM = 8'd2;
    localparam logic [7:0] MAP_CNROM = 8'd3;

    // Nametable mirroring encodings
    localparam logic [1:0] MIR_ONE_A = 2'd0;
    localparam logic [1:0] MIR_ONE_B = 2'd1;
    localparam logic [1:0] MIR_VERT  = 2'd2;
    localparam logic [1:0] MIR_HORZ  = 2'd3;

    // MMC1 control after power-up or a bit-7 write: PRG mode 3
    localparam logic [4:0] MMC1_CTRL_RST = 5'h0C;

    // MMC1 internal register selected by cpu_a[14:13] on the fifth write
    typedef enum logic [1:0] {
        MMC1_REG_CTRL = 2'd0,
        MMC1_REG_CHR0 = 2'd1,
        MMC1_REG_CHR1 = 2'd2,
        MMC1_REG_PRG  = 2'd3
    } mmc1_reg_e;

endpackage

// File: rtl/mmc1_serial.sv
// MMC1 serial port: 5-write shift loader plus the four internal registers.
module mmc1_serial
    import mapper_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_tick,     // CPU cycle-complete tick
    input  logic       i_we,       // qualified mapper write (only meaningful with i_tick)
    input  logic [1:0] i_sel,      // cpu_a[14:13]
    input  logic [7:0] i_data,
    output logic [4:0] o_control,
    output logic [4:0] o_chr0,
    output logic [4:0] o_chr1,
    output logic [4:0] o_prg
);

    logic [4:0] r_sr;
    logic [2:0] r_cnt;
    logic       r_last_w;
    logic [4:0] r_control;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;

    logic [4:0] w_data;
    logic       w_unused;

    // New bit enters at the top so the first write ends up in bit 0
    assign w_data   = {i_data[0], r_sr[4:1]};
    assign w_unused = ^i_data[6:1];

    // Shift/load sequencing with the back-to-back (RMW) write filter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sr      <= 5'd0;
            r_cnt     <= 3'd0;
            r_last_w  <= 1'b0;
            r_control <= MMC1_CTRL_RST;
            r_chr0    <= 5'd0;
            r_chr1    <= 5'd0;
            r_prg     <= 5'd0;
        end else if (i_tick) begin
            if (!i_we) begin
                r_last_w <= 1'b0;
            end else if (!r_last_w) begin
                r_last_w <= 1'b1;
                if (i_data[7]) begin
                    r_sr      <= 5'd0;
                    r_cnt     <= 3'd0;
                    r_control <= r_control | MMC1_CTRL_RST;
                end else if (r_cnt == 3'd4) begin
                    unique case (mmc1_reg_e'(i_sel))
                        MMC1_REG_CTRL: r_control <= w_data;
                        MMC1_REG_CHR0: r_chr0    <= w_data;
                        MMC1_REG_CHR1: r_chr1    <= w_data;
                        MMC1_REG_PRG:  r_prg     <= w_data;
                    endcase
                    r_sr  <= 5'd0;
                    r_cnt <= 3'd0;
                end else begin
                    r_sr  <= w_data;
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    assign o_control = r_control;
    assign o_chr0    = r_chr0;
    assign o_chr1    = r_chr1;
    assign o_prg     = r_prg;

endmodule

// File: rtl/mapper_multi.sv
// Cartridge mapper for NROM, MMC1, UxROM and CNROM: bank registers plus
// CPU PRG / PPU CHR address translation, mirroring and PRG-RAM enable.
module mapper_multi
    import mapper_pkg::*;
#(
    parameter int unsigned PRG_W = 18,
    parameter int unsigned CHR_W = 17
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        num,
    input  logic [PRG_W-15:0] prg_max,
    input  logic              mirror_h,
    input  logic              chr_ram,
    input  logic              ct_cpu,
    input  logic [15:0]       cpu_a,
    input  logic [7:0]        cpu_o,
    input  logic              cpu_w,
    input  logic [15:0]       program_a,
    input  logic [12:0]       ppu_a,
    output logic [PRG_W-1:0]  program_m,
    output logic [CHR_W-1:0]  chr_m,
    output logic              cw,
    output logic [1:0]        mirror,
    output logic              wram_en
);

    localparam int unsigned PB  = PRG_W - 14;  // 16 KB PRG bank index width
    localparam int unsigned CB8 = CHR_W - 13;  // 8 KB CHR bank index width
    localparam int unsigned CB4 = CHR_W - 12;  // 4 KB CHR bank index width

    logic [PB-1:0]  r_pbank;
    logic [CB8-1:0] r_cbank0;
    logic           r_cw;

    logic           w_w;
    logic           w_is_mmc1;
    logic           w_is_uxrom;
    logic           w_is_cnrom;
    logic [4:0]     w_control;
    logic [4:0]     w_chr0;
    logic [4:0]     w_chr1;
    logic [4:0]     w_prg;
    logic [7:0]     w_mmc1_idx;
    logic [PB-1:0]  w_prg_bank;
    logic [7:0]     w_chr4_idx;
    logic           w_unused;

    assign w_w        = ct_cpu & cpu_w & cpu_a[15];
    assign w_is_mmc1  = (num == MAP_MMC1);
    assign w_is_uxrom = (num == MAP_UXROM);
    assign w_is_cnrom = (num == MAP_CNROM);
    assign w_unused   = ^{cpu_a[12:0], program_a[15], cpu_o, w_mmc1_idx, w_chr4_idx};

    mmc1_serial u_mmc1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_tick    (ct_cpu),
        .i_we      (w_w & w_is_mmc1),
        .i_sel     (cpu_a[14:13]),
        .i_data    (cpu_o),
        .o_control (w_control),
        .o_chr0    (w_chr0),
        .o_chr1    (w_chr1),
        .o_prg     (w_prg)
    );

    // UxROM/CNROM bank latches and the registered CHR write enable
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pbank  <= '0;
            r_cbank0 <= '0;
            r_cw     <= 1'b0;
        end else begin
            r_cw <= chr_ram;
            if (w_w && w_is_uxrom) r_pbank  <= cpu_o[PB-1:0];
            if (w_w && w_is_cnrom) r_cbank0 <= cpu_o[CB8-1:0];
        end
    end

    // 16 KB PRG bank selection; program_a[14] picks the $8000 or $C000 window
    always_comb begin
        w_mmc1_idx = 8'd0;
        w_prg_bank = '0;
        case (w_control[3:2])
            2'd0, 2'd1: w_mmc1_idx = {4'd0, w_prg[3:1], program_a[14]};
            2'd2:       w_mmc1_idx = program_a[14] ? {4'd0, w_prg[3:0]} : 8'd0;
            default:    w_mmc1_idx = {4'd0, w_prg[3:0]};
        endcase
        if (w_is_mmc1) begin
            if (w_control[3:2] == 2'd3 && program_a[14]) w_prg_bank = prg_max;
            else                                         w_prg_bank = w_mmc1_idx[PB-1:0];
        end else if (w_is_uxrom) begin
            w_prg_bank = program_a[14] ? prg_max : r_pbank;
        end else begin
            // 16 KB images (prg_max = 0) mirror into both windows
            w_prg_bank[0] = program_a[14] & (|prg_max);
        end
    end

    assign program_m = {w_prg_bank, program_a[13:0]};

    // CHR address: MMC1 4/8 KB banking, CNROM 8 KB banking, otherwise flat
    always_comb begin
        if (w_control[4]) w_chr4_idx = ppu_a[12] ? {3'd0, w_chr1} : {3'd0, w_chr0};
        else              w_chr4_idx = {3'd0, w_chr0[4:1], ppu_a[12]};
        if (w_is_mmc1)       chr_m = {w_chr4_idx[CB4-1:0], ppu_a[11:0]};
        else if (w_is_cnrom) chr_m = {r_cbank0, ppu_a[12:0]};
        else                 chr_m = {{(CHR_W-13){1'b0}}, ppu_a};
    end

    // Mirroring and PRG-RAM enable
    always_comb begin
        mirror  = mirror_h ? MIR_VERT : MIR_HORZ;
        wram_en = 1'b1;
        if (w_is_mmc1) begin
            mirror  = w_control[1:0];
            wram_en = ~w_prg[4];
        end
    end

    assign cw = r_cw;

endmodule

// File: tb/tb_mapper_multi.sv
// Self-checking bench for mapper_multi: behavioural model compared every
// cycle, directed literal scenarios, then a randomized phase.
module tb_mapper_multi;

    localparam int PRG_W = 18;
    localparam int CHR_W = 17;
    localparam int PB    = PRG_W - 14;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        num = 8'd0;
    logic [PB-1:0]     prg_max = '0;
    logic              mirror_h = 1'b0;
    logic              chr_ram = 1'b0;
    logic              ct_cpu = 1'b0;
    logic [15:0]       cpu_a = 16'h0000;
    logic [7:0]        cpu_o = 8'h00;
    logic              cpu_w = 1'b0;
    logic [15:0]       program_a = 16'h8000;
    logic [12:0]       ppu_a = 13'h0000;
    logic [PRG_W-1:0]  program_m;
    logic [CHR_W-1:0]  chr_m;
    logic              cw;
    logic [1:0]        mirror;
    logic              wram_en;

    mapper_multi #(.PRG_W(PRG_W), .CHR_W(CHR_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .num       (num),
        .prg_max   (prg_max),
        .mirror_h  (mirror_h),
        .chr_ram   (chr_ram),
        .ct_cpu    (ct_cpu),
        .cpu_a     (cpu_a),
        .cpu_o     (cpu_o),
        .cpu_w     (cpu_w),
        .program_a (program_a),
        .ppu_a     (ppu_a),
        .program_m (program_m),
        .chr_m     (chr_m),
        .cw        (cw),
        .mirror    (mirror),
        .wram_en   (wram_en)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: MMC1 registers, collected serial bits, filter flag, simple banks
    int m_ctrl, m_chr0, m_chr1, m_prg, m_bits, m_n, m_pbank, m_cbank, m_cw;
    bit m_last;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_bits = 0; m_n = 0; m_pbank = 0; m_cbank = 0; m_cw = 0; m_last = 0;
    endtask

    // Apply one rising edge to the model using the inputs held across it
    task automatic model_edge();
        bit w;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_cw = chr_ram;
        if (!ct_cpu) return;
        w = cpu_w && cpu_a[15];
        if (w && num == 2) m_pbank = cpu_o % (1 << PB);
        if (w && num == 3) m_cbank = cpu_o % (1 << (CHR_W - 13));
        if (!(w && num == 1)) begin
            m_last = 0;
            return;
        end
        if (m_last) return;
        m_last = 1;
        if (cpu_o[7]) begin
            m_n = 0; m_bits = 0; m_ctrl = m_ctrl | 12;
        end else begin
            m_bits = m_bits + (int'(cpu_o[0]) << m_n);
            if (m_n == 4) begin
                case ((cpu_a >> 13) & 3)
                    0: m_ctrl = m_bits;
                    1: m_chr0 = m_bits;
                    2: m_chr1 = m_bits;
                    default: m_prg = m_bits;
                endcase
                m_n = 0; m_bits = 0;
            end else begin
                m_n++;
            end
        end
    endtask

    function automatic longint exp_prg();
        int a = int'(program_a);
        int hi = (a >> 14) & 1;
        int mode = (m_ctrl >> 2) & 3;
        int bank;
        if (num == 1) begin
            if (mode < 2)       bank = ((m_prg >> 1) & 7) * 2 + hi;
            else if (mode == 2) bank = hi ? (m_prg & 15) : 0;
            else                bank = hi ? int'(prg_max) : (m_prg & 15);
        end else if (num == 2) begin
            bank = hi ? int'(prg_max) : m_pbank;
        end else begin
            bank = (prg_max != 0) ? hi : 0;
        end
        return longint'((bank % (1 << PB)) * 16384 + (a % 16384));
    endfunction

    function automatic longint exp_chr();
        int p = int'(ppu_a);
        int idx;
        if (num == 1) begin
            if ((m_ctrl >> 4) & 1) idx = ((p >> 12) & 1) ? m_chr1 : m_chr0;
            else                   idx = (m_chr0 >> 1) * 2 + ((p >> 12) & 1);
            return longint'((idx % (1 << (CHR_W - 12))) * 4096 + (p % 4096));
        end
        if (num == 3) return longint'(m_cbank * 8192 + p);
        return longint'(p);
    endfunction

    function automatic longint exp_mirror();
        if (num == 1) return longint'(m_ctrl & 3);
        return mirror_h ? 2 : 3;
    endfunction

    function automatic longint exp_wram();
        if (num == 1) return ((m_prg >> 4) & 1) ? 0 : 1;
        return 1;
    endfunction

    // Compare every cycle on the falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            check("program_m", longint'(program_m), exp_prg());
            check("chr_m", longint'(chr_m), exp_chr());
            check("mirror", longint'(mirror), exp_mirror());
            check("wram_en", longint'(wram_en), exp_wram());
            check("cw", longint'(cw), longint'(m_cw));
        end
    end

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic bus(input bit ct, input bit w, input logic [15:0] a, input logic [7:0] d);
        ct_cpu = ct; cpu_w = w; cpu_a = a; cpu_o = d;
        step();
        ct_cpu = 1'b0; cpu_w = 1'b0;
    endtask

    // One serial bit followed by a quiet tick so the next write is accepted
    task automatic mmc1_bit(input logic [15:0] a, input bit b);
        bus(1'b1, 1'b1, a, {7'd0, b});
        bus(1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic mmc1_load(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) mmc1_bit(a, v[i]);
    endtask

    task automatic lit_prg(input string name, input logic [15:0] a, input longint exp);
        program_a = a;
        #1;
        check(name, longint'(program_m), exp);
    endtask

    task automatic lit_chr(input string name, input logic [12:0] p, input longint exp);
        ppu_a = p;
        #1;
        check(name, longint'(chr_m), exp);
    endtask

    initial begin
        // Reset with MMC1 selected
        reset_n = 1'b0; num = 8'd1; prg_max = 4'd15; chr_ram = 1'b1;
        step(); step();
        chk_en = 1'b1;
        check("rst_cw", longint'(cw), 0);
        reset_n = 1'b1;
        lit_prg("rst_c123", 16'hC123, 'h3C123);
        lit_prg("rst_8123", 16'h8123, 'h00123);
        check("rst_mirror", longint'(mirror), 0);
        check("rst_wram", longint'(wram_en), 1);
        step();
        check("cw_follow", longint'(cw), 1);

        // Serial load prg = 2 (mode 3)
        mmc1_load(16'hE000, 5'b00010);
        lit_prg("mmc1_prg2", 16'h8000, 'h08000);

        // Bit-7 write aborts a partial sequence
        mmc1_bit(16'h8000, 1'b1);
        mmc1_bit(16'h8000, 1'b1);
        bus(1'b1, 1'b1, 16'h8000, 8'h80);
        bus(1'b1, 1'b0, 16'h0000, 8'h00);
        mmc1_load(16'hE000, 5'd3);
        lit_prg("mmc1_abort", 16'h8000, 'h0C000);
        check("mmc1_abort_mir", longint'(mirror), 0);

        // Back-to-back W ticks: only the first shifts
        bus(1'b1, 1'b1, 16'hE000, 8'h01);
        bus(1'b1, 1'b1, 16'hE000, 8'h01);
        bus(1'b1, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 4; i++) mmc1_bit(16'hE000, 1'b0);
        lit_prg("mmc1_rmw", 16'h8000, 'h04000);

        // CHR 4 KB mode, vertical mirroring
        mmc1_load(16'h8000, 5'h12);
        mmc1_load(16'hA000, 5'd3);
        mmc1_load(16'hC000, 5'd5);
        lit_chr("mmc1_chr0", 13'h0010, 'h3010);
        lit_chr("mmc1_chr1", 13'h1010, 'h5010);
        check("mmc1_mirror", longint'(mirror), 2);

        // UxROM
        num = 8'd2; prg_max = 4'd7;
        bus(1'b1, 1'b1, 16'h8000, 8'h05);
        lit_prg("uxrom_8000", 16'h8000, 'h14000);
        lit_prg("uxrom_c000", 16'hC000, 'h1C000);
        bus(1'b1, 1'b1, 16'h6000, 8'h03);
        lit_prg("uxrom_6000w", 16'h8000, 'h14000);

        // CNROM
        num = 8'd3; mirror_h = 1'b1;
        bus(1'b1, 1'b1, 16'h8000, 8'h02);
        lit_chr("cnrom_chr", 13'h0ABC, 'h04ABC);
        check("cnrom_mirror", longint'(mirror), 2);
        check("cnrom_wram", longint'(wram_en), 1);

        // Reset in the middle of an MMC1 load
        num = 8'd1; prg_max = 4'd15;
        for (int i = 0; i < 3; i++) mmc1_bit(16'hE000, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rst_mid_mirror", longint'(mirror), 0);
        mmc1_load(16'hE000, 5'd6);
        lit_prg("rst_mid_prg", 16'h8000, 'h18000);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 5))
                    0: num = 8'd0;
                    1, 2: num = 8'd1;
                    3: num = 8'd2;
                    4: num = 8'd3;
                    default: num = 8'($urandom_range(4, 255));
                endcase
                prg_max = PB'($urandom);
            end
            mirror_h  = 1'($urandom);
            chr_ram   = 1'($urandom);
            ct_cpu    = 1'($urandom);
            cpu_w     = 1'($urandom);
            cpu_a     = 16'($urandom);
            cpu_a[15] = ($urandom_range(0, 9) < 7);
            cpu_o     = 8'($urandom);
            cpu_o[7]  = ($urandom_range(0, 7) == 0);
            program_a = 16'h8000 | 16'($urandom);
            ppu_a     = 13'($urandom);
            step();
        end
        ct_cpu = 1'b0; cpu_w = 1'b0; reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
